jk_bank_driver: RTL and testbench

- Command-side controller for a bank of WIDTH jk_flip_flop cells.
- Accepts word-level register commands (load/set/clear/toggle) over a valid/ready handshake and computes per-bit J/K excitation from the bank's current Q.
- Drives J/K for one cycle, reads Q back to verify the result, retries on mismatch, and returns a one-cycle response.
- Sits between a control FSM or CPU-side register and a discrete JK storage bank.

---
 rtl/jk_bank_pkg.sv | 16 +
 rtl/jk_excitation.sv | 12 +
 rtl/jk_flip_flop.sv | 12 +
 rtl/jk_bank_driver.sv | 68 ++++++
 tb/tb_jk_bank_driver.sv | 122 ++++++++++++
 5 files changed

// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg: shared op codes, FSM states and target computation for JK bank drivers
package jk_bank_pkg;
    localparam int MAX_W = 64;
    localparam logic [1:0] OP_LOAD   = 2'd0;
    localparam logic [1:0] OP_SET    = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam logic [1:0] OP_TOGGLE = 2'd3;
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, RESP} state_t;
    function automatic logic [MAX_W-1:0] calc_target(input logic [1:0] op,
                                                     input logic [MAX_W-1:0] q,
                                                     input logic [MAX_W-1:0] data);
        return op == OP_LOAD  ? data :
               op == OP_SET   ? q | data :
               op == OP_CLEAR ? q & ~data : q ^ data;
    endfunction
endpackage

// File: rtl/jk_excitation.sv
// jk_excitation: per-bit J/K needed to move q to target; toggle is never used, so j&k is always 0
module jk_excitation #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);
    assign j = target & ~q;
    assign k = ~target & q;
endmodule

// File: rtl/jk_flip_flop.sv
// jk_flip_flop: single JK storage cell with asynchronous active-high reset
module jk_flip_flop (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= 1'b0;
        else     q <= j && k ? ~q : j ? 1'b1 : k ? 1'b0 : q;
endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: word commands to a JK bank as one-cycle J/K pulses with readback verify and retry
module jk_bank_driver
    import jk_bank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_q
);
    localparam int RW = $clog2(MAX_RETRY + 2);
    state_t state, next_state;
    logic [WIDTH-1:0] t, t_next, exc_t, j_next, k_next;
    logic [RW-1:0] retry;
    logic accept, match, can_retry, drive_load, finish;
    assign req_ready  = state == IDLE && !rst;
    assign accept     = req_valid && req_ready;
    assign t_next     = WIDTH'(calc_target(req_op, MAX_W'(q_fb), MAX_W'(req_data)));
    assign exc_t      = state == IDLE ? t_next : t;
    assign match      = q_fb == t;
    assign can_retry  = retry < RW'(MAX_RETRY);
    assign drive_load = accept || (state == CHECK && !match && can_retry);
    assign finish     = state == CHECK && next_state == RESP;
    // Retries re-excite from the current readback, not from the original q
    jk_excitation #(.WIDTH(WIDTH)) u_exc (
        .q     (q_fb),
        .target(exc_t),
        .j     (j_next),
        .k     (k_next)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next_state;
    always_comb begin
        next_state = state;
        next_state = state == IDLE  ? (accept ? DRIVE : IDLE) :
                     state == DRIVE ? CHECK :
                     state == CHECK ? (match || !can_retry ? RESP : DRIVE) : IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            j         <= '0;
            k         <= '0;
            t         <= '0;
            retry     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_q     <= '0;
        end else begin
            j         <= drive_load ? j_next : '0;
            k         <= drive_load ? k_next : '0;
            t         <= accept ? t_next : t;
            retry     <= state == RESP ? '0 : (state == CHECK && next_state == DRIVE) ? retry + 1'b1 : retry;
            rsp_valid <= finish;
            rsp_err   <= finish ? !match : rsp_err;
            rsp_q     <= finish ? q_fb : rsp_q;
        end
endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: directed bench driving a real JK cell bank through jk_bank_driver
module tb_jk_bank_driver;
    import jk_bank_pkg::*;
    logic clk = 0, rst = 1, bank_rst = 1;
    logic req_valid = 0, req_ready, rsp_valid, rsp_err;
    logic [1:0] req_op = 0;
    logic [7:0] req_data = 0, q_fb, j, k, rsp_q, bank_q, stuck = 0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    assign q_fb = bank_q & ~stuck;
    for (genvar i = 0; i < 8; i++) begin : g_bank
        jk_flip_flop u_ff (.clk(clk), .rst(bank_rst), .j(j[i]), .k(k[i]), .q(bank_q[i]));
    end
    jk_bank_driver #(.WIDTH(8), .MAX_RETRY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .q_fb(q_fb), .j(j), .k(k),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_q(rsp_q)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [7:0] data,
                          input logic [7:0] exp_j, input logic [7:0] exp_k, input logic [7:0] exp_q,
                          input logic exp_err, input int exp_lat, input int exp_pulses);
        int n = 0, lat = 0, pulses = 0;
        logic ovl = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check({tag, "_ready"}, req_ready, 1);
        req_valid = 1; req_op = op; req_data = data;
        @(posedge clk); #1 req_valid = 0;
        check({tag, "_j"}, j, exp_j);
        check({tag, "_k"}, k, exp_k);
        while (!rsp_valid && lat < 20) begin
            pulses += ((j | k) != 0) ? 1 : 0;
            ovl |= |(j & k);
            @(posedge clk); #1 lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_pulses"}, pulses, exp_pulses);
        check({tag, "_jk_overlap"}, ovl, 0);
        check({tag, "_rsp_q"}, rsp_q, exp_q);
        check({tag, "_rsp_err"}, rsp_err, exp_err);
        @(posedge clk); #1;
        check({tag, "_rsp_drop"}, rsp_valid, 0);
        check({tag, "_jk_idle"}, j | k, 0);
        check({tag, "_rsp_q_hold"}, rsp_q, exp_q);
    endtask
    task automatic watch_no_rsp(input string tag);
        int seen = 0;
        repeat (6) begin @(posedge clk); #1 seen += rsp_valid ? 1 : 0; end
        check({tag, "_no_rsp"}, seen, 0);
        check({tag, "_ready_after"}, req_ready, 1);
    endtask
    initial begin
        int n_rsp = 0, c1 = 0, c2 = 0;
        logic [7:0] q1 = 0, q2 = 0;
        #1 check("rst_ready", req_ready, 0);
        @(negedge clk); @(negedge clk);
        check("rst_jk", {j, k}, 0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_q}, 0);
        rst = 0; bank_rst = 0;
        #1 check("ready_after_rst", req_ready, 1);
        do_cmd("load_a5",    OP_LOAD,   8'hA5, 8'hA5, 8'h00, 8'hA5, 0, 2, 1);
        do_cmd("toggle_0f",  OP_TOGGLE, 8'h0F, 8'h0A, 8'h05, 8'hAA, 0, 2, 1);
        do_cmd("set_zero",   OP_SET,    8'h00, 8'h00, 8'h00, 8'hAA, 0, 2, 0);
        do_cmd("clear_f0",   OP_CLEAR,  8'hF0, 8'h00, 8'hA0, 8'h0A, 0, 2, 1);
        stuck = 8'h01;
        do_cmd("stuck_load", OP_LOAD,   8'h01, 8'h01, 8'h0A, 8'h00, 1, 6, 3);
        stuck = 8'h00;
        check("bank_after_stuck", bank_q, 8'h01);
        // Abort while J/K are being driven
        @(negedge clk);
        req_valid = 1; req_op = OP_LOAD; req_data = 8'h3C;
        @(posedge clk); #1 req_valid = 0;
        check("abort_drive_j", j, 8'h3C);
        #2 rst = 1;
        #1 check("abort_drive_jk", {j, k}, 0);
        check("abort_drive_ready", req_ready, 0);
        @(negedge clk) rst = 0;
        check("abort_drive_bank", bank_q, 8'h01);
        watch_no_rsp("abort_drive");
        // Abort during readback check
        @(negedge clk);
        req_valid = 1; req_op = OP_LOAD; req_data = 8'hFF;
        @(posedge clk); #1 req_valid = 0;
        @(posedge clk); #3 rst = 1;
        #1 check("abort_check_out", {j, k, 7'd0, rsp_valid}, 0);
        @(negedge clk) rst = 0;
        check("abort_check_bank", bank_q, 8'hFF);
        watch_no_rsp("abort_check");
        do_cmd("load_3c", OP_LOAD, 8'h3C, 8'h00, 8'hC3, 8'h3C, 0, 2, 1);
        // Held request: second command must wait for RESP and be taken exactly once
        @(negedge clk);
        req_valid = 1; req_op = OP_LOAD; req_data = 8'h11;
        @(posedge clk); #1 req_data = 8'h22;
        check("b2b_first_jk", {j, k}, {8'h01, 8'h2C});
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 4) begin
                check("b2b_second_jk", {j, k}, {8'h22, 8'h11});
                req_valid = 0;
            end
            if (rsp_valid) begin
                n_rsp++;
                if (n_rsp == 1) begin c1 = c; q1 = rsp_q; end
                else begin c2 = c; q2 = rsp_q; end
            end
        end
        check("b2b_rsp_count", n_rsp, 2);
        check("b2b_rsp1_cycle", c1, 2);
        check("b2b_rsp1_q", q1, 8'h11);
        check("b2b_rsp2_cycle", c2, 6);
        check("b2b_rsp2_q", q2, 8'h22);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
